// File: rtl/serial_rx_frame.sv
// Framed serial-to-parallel receiver: start bit, N data bits LSB-first, stop bit.
// Good frames update o with a one-cycle valid pulse; a bad stop bit pulses frame_err.
module serial_rx_frame #(
   parameter int unsigned N = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         din,
   input  logic         bit_en,
   output logic [N-1:0] o,
   output logic         valid,
   output logic         frame_err,
   output logic         busy
);

   localparam int unsigned CW = $clog2(N + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StData = 2'd1;
   localparam logic [1:0] StStop = 2'd2;

   localparam logic [CW-1:0] CntFull = CW'(N);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_sh;
   logic [N-1:0]  r_o;
   logic          r_valid;
   logic          r_frame_err;

   logic [N-1:0]  w_sh_next;
   logic [CW-1:0] w_cnt_next;
   logic          w_busy;

   // New bit enters at the MSB so the first data bit ends up in bit 0.
   generate
      if (N == 1) begin : g_sh_one
         assign w_sh_next = din;
      end else begin : g_sh_wide
         assign w_sh_next = {din, r_sh[N-1:1]};
      end
   endgenerate

   always_comb begin
      w_cnt_next = r_cnt + 1'b1;
      w_busy     = (r_state != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_sh        <= '0;
         r_o         <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         if (bit_en) begin
            case (r_state)
               StIdle: begin
                  if (!din) begin
                     r_state <= StData;
                     r_cnt   <= '0;
                  end
               end
               StData: begin
                  r_sh  <= w_sh_next;
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == CntFull) begin
                     r_state <= StStop;
                  end
               end
               StStop: begin
                  if (din) begin
                     r_o     <= r_sh;
                     r_valid <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
                  r_state <= StIdle;
                  r_cnt   <= '0;
               end
               default: begin
                  r_state <= StIdle;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign o         = r_o;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign busy      = w_busy;

endmodule

// File: tb/tb_serial_rx_frame.sv
// Scoreboard bench for serial_rx_frame: the driver queues expected events per cycle,
// the monitor pops them and compares every output each cycle.
module tb_serial_rx_frame;

   localparam int unsigned N = 10;

   localparam int KStart = 0;
   localparam int KGood  = 1;
   localparam int KErr   = 2;
   localparam int KReset = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         din = 1'b1;
   logic         bit_en = 1'b0;
   logic [N-1:0] o;
   logic         valid;
   logic         frame_err;
   logic         busy;

   always #5 clk = ~clk;

   serial_rx_frame #(.N(N)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .bit_en    (bit_en),
      .o         (o),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   typedef struct {
      int           cyc;
      int           kind;
      logic [N-1:0] word;
   } ev_t;

   ev_t          q[$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   logic         mon_en = 1'b0;
   int           last_edge = 0;
   logic [N-1:0] exp_o = '0;
   logic         exp_valid = 1'b0;
   logic         exp_err = 1'b0;
   logic         exp_busy = 1'b0;

   function automatic void check(input string name, input logic [N-1:0] act,
                                 input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endfunction

   // Monitor: cycle c is the interval just after rising edge number c.
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         exp_valid = 1'b0;
         exp_err   = 1'b0;
         while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.kind)
               KStart: exp_busy = 1'b1;
               KGood: begin
                  exp_valid = 1'b1;
                  exp_o     = e.word;
                  exp_busy  = 1'b0;
               end
               KErr: begin
                  exp_err  = 1'b1;
                  exp_busy = 1'b0;
               end
               default: begin
                  exp_o     = '0;
                  exp_busy  = 1'b0;
                  exp_valid = 1'b0;
                  exp_err   = 1'b0;
               end
            endcase
         end
         if (mon_en) begin
            check("valid", N'(valid), N'(exp_valid));
            check("frame_err", N'(frame_err), N'(exp_err));
            check("o", o, exp_o);
            check("busy", N'(busy), N'(exp_busy));
         end
      end
   end

   task automatic push(input int c, input int k, input logic [N-1:0] w);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.word = w;
      q.push_back(e);
   endtask

   task automatic hold_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         reset  = 1'b0;
         bit_en = 1'b0;
         din    = 1'($urandom);
      end
   endtask

   task automatic strobe(input logic d, input int gap);
      hold_cycles(gap);
      @(negedge clk);
      reset     = 1'b0;
      bit_en    = 1'b1;
      din       = d;
      last_edge = cyc + 1;
   endtask

   task automatic do_reset(input logic be, input logic d);
      @(negedge clk);
      reset  = 1'b1;
      bit_en = be;
      din    = d;
      push(cyc + 1, KReset, '0);
   endtask

   task automatic start_frame(input logic [N-1:0] w, input int nbits, input int gap);
      strobe(1'b0, gap);
      push(last_edge, KStart, '0);
      for (int i = 0; i < nbits; i++) strobe(w[i], gap);
   endtask

   task automatic send_frame(input logic [N-1:0] w, input logic stop_bit, input int gap);
      start_frame(w, N, gap);
      strobe(stop_bit, gap);
      push(last_edge, stop_bit ? KGood : KErr, w);
   endtask

   initial begin
      int           r;
      int           gap;
      logic [N-1:0] w;

      mon_en = 1'b1;
      repeat (3) do_reset(1'b1, 1'b1);
      repeat (5) strobe(1'b1, 0);

      send_frame(10'h020, 1'b1, 0);
      send_frame(10'h015, 1'b1, 0);
      send_frame(10'h3FF, 1'b1, 0);
      send_frame(10'h0AA, 1'b0, 0);
      hold_cycles(2);
      send_frame(10'h155, 1'b1, 3);
      start_frame(10'h2C3, 4, 0);
      do_reset(1'b1, 1'b0);
      hold_cycles(2);
      send_frame(10'h2C3, 1'b1, 0);

      for (int i = 0; i < 60; i++) begin
         r   = int'($urandom_range(0, 9));
         gap = int'($urandom_range(0, 3));
         w   = N'($urandom);
         if (r == 0) begin
            start_frame(w, int'($urandom_range(0, N)), gap);
            do_reset(1'($urandom), 1'($urandom));
         end else begin
            send_frame(w, r != 1, gap);
         end
         if ($urandom_range(0, 3) == 0) strobe(1'b1, gap);
      end

      hold_cycles(6);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d pending events required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
